// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: sequential instruction prefetch feeding decode from an in-order slot ring.
// Optional macro IF_PREFETCH_PERF_EN adds saturating fetched/dropped event counters.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
`ifdef IF_PREFETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
`endif
    input  logic        clk,
    input  logic        Reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] fptr_q, fptr_d;
    logic [CW-1:0] reserved_q, reserved_d;
    logic [CW-1:0] pending_q, pending_d;
    logic [15:0]   discard_q, discard_d;

    logic [63:0]   slot_pc_q    [DEPTH];
    logic [31:0]   slot_instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;

    logic [63:0]   hold_pc_q;
    logic [31:0]   hold_instr_q;

    logic          grant;
    logic          pop;
    logic          drop;
    logic          fill;
    logic [CW-1:0] pending_left;

    // Issue is gated only by registered occupancy, so a pop cannot free a slot the same cycle.
    assign imem_req  = Reset && (reserved_q != CW'(DEPTH)) && !redirect;
    assign imem_addr = fetch_pc_q;

    assign id_valid = filled_q[head_q];
    assign id_instr = id_valid ? slot_instr_q[head_q] : hold_instr_q;
    assign id_pc    = id_valid ? slot_pc_q[head_q] : hold_pc_q;

    assign grant = imem_req && imem_gnt;
    assign pop   = id_valid && id_ready && !redirect;
    assign drop  = imem_rvalid && (discard_q != '0);
    assign fill  = imem_rvalid && !drop && (pending_q != '0);

    assign pending_left = pending_q - CW'(fill);

    // Next-state for fetch PC, ring pointers and outstanding bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fptr_d     = fptr_q;
        reserved_d = reserved_q;
        pending_d  = pending_q;
        discard_d  = discard_q - 16'(drop);
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~64'h3;
            head_d     = '0;
            tail_d     = '0;
            fptr_d     = '0;
            reserved_d = '0;
            pending_d  = '0;
            discard_d  = discard_d + 16'(pending_left);
        end else begin
            if (grant) begin
                tail_d     = tail_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            if (fill) begin
                fptr_d = fptr_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            reserved_d = reserved_q + CW'(grant) - CW'(pop);
            pending_d  = pending_q + CW'(grant) - CW'(fill);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            fptr_q     <= '0;
            reserved_q <= '0;
            pending_q  <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fptr_q     <= fptr_d;
            reserved_q <= reserved_d;
            pending_q  <= pending_d;
            discard_q  <= discard_d;
        end
    end

    // Slot ring: reserve at tail, fill oldest unfilled, release at head.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            filled_q <= '0;
        end else if (redirect) begin
            filled_q <= '0;
        end else begin
            if (grant) begin
                slot_pc_q[tail_q] <= fetch_pc_q;
                filled_q[tail_q]  <= 1'b0;
            end
            if (fill) begin
                slot_instr_q[fptr_q] <= imem_rdata;
                filled_q[fptr_q]     <= 1'b1;
            end
            if (pop) begin
                filled_q[head_q] <= 1'b0;
            end
        end
    end

    // Remember the last presented entry so outputs hold while the queue is empty.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else if (id_valid) begin
            hold_pc_q    <= slot_pc_q[head_q];
            hold_instr_q <= slot_instr_q[head_q];
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_dropped_q;

    // Saturating counters for delivered and discarded instructions.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            if (pop && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (drop && (perf_dropped_q != 32'hFFFF_FFFF)) begin
                perf_dropped_q <= perf_dropped_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: randomized memory/decode traffic against a queue-level reference model.
// Optional macro IF_PREFETCH_PERF_EN also checks the event counters.
module tb_if_prefetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h0;

    logic        clk = 1'b0;
    logic        Reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic        id_ready;
    logic        redirect;
    logic [63:0] redirect_pc;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    always #5 clk = ~clk;

    if_prefetch_queue #(
        .DEPTH(DEPTH),
        .RESET_PC(RPC)
    ) dut (
`ifdef IF_PREFETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped),
`endif
        .clk(clk),
        .Reset(Reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .id_valid(id_valid),
        .id_instr(id_instr),
        .id_pc(id_pc),
        .id_ready(id_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [63:0] addr;
        int          gcyc;
    } req_t;

    ent_t        mq[$];
    req_t        mem[$];
    logic [63:0] m_pc;
    int          m_disc;
    int          m_fetched;
    int          m_dropped;
    int          cyc;
    int          seq;
    int          checks;
    int          failures;
    int          p_gnt, p_rv, p_rdy, p_redir, p_spur;
    bit          f_redir;
    logic [63:0] f_rpc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit e_req;
        bit e_valid;
        int unf;
        @(negedge clk);
        imem_gnt    = ($urandom_range(99) < p_gnt);
        id_ready    = ($urandom_range(99) < p_rdy);
        redirect    = f_redir || ($urandom_range(99) < p_redir);
        redirect_pc = f_redir ? f_rpc : {$urandom, $urandom};
        f_redir     = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem.size() > 0 && mem[0].gcyc < cyc && $urandom_range(99) < p_rv) begin
            seq++;
            imem_rvalid = 1'b1;
            imem_rdata  = {mem[0].addr[17:2], seq[15:0]};
            void'(mem.pop_front());
        end else if (mem.size() == 0 && $urandom_range(99) < p_spur) begin
            imem_rvalid = 1'b1;
        end
        #1;
        e_req   = (mq.size() < DEPTH) && !redirect;
        e_valid = (mq.size() > 0) && mq[0].filled;
        chk("imem_req", 64'(imem_req), 64'(e_req));
        if (e_req) chk("imem_addr", imem_addr, m_pc);
        chk("id_valid", 64'(id_valid), 64'(e_valid));
        if (e_valid) begin
            chk("id_pc", id_pc, mq[0].pc);
            chk("id_instr", 64'(id_instr), 64'(mq[0].instr));
        end
`ifdef IF_PREFETCH_PERF_EN
        chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
        chk("perf_dropped", 64'(perf_dropped), 64'(m_dropped));
`endif
        @(posedge clk);
        if (imem_rvalid) begin
            if (m_disc > 0) begin
                m_disc--;
                m_dropped++;
            end else begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].filled) begin
                        mq[i].instr  = imem_rdata;
                        mq[i].filled = 1'b1;
                        break;
                    end
                end
            end
        end
        if (redirect) begin
            unf = 0;
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].filled) unf++;
            end
            m_disc += unf;
            mq.delete();
            m_pc = redirect_pc & ~64'h3;
        end else begin
            if (e_valid && id_ready) begin
                void'(mq.pop_front());
                m_fetched++;
            end
            if (e_req && imem_gnt) begin
                mq.push_back('{pc: m_pc, instr: 32'h0, filled: 1'b0});
                mem.push_back('{addr: m_pc, gcyc: cyc});
                m_pc = m_pc + 64'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        id_ready    = 1'b0;
        #1;
        chk("rst_req", 64'(imem_req), 64'h0);
        chk("rst_valid", 64'(id_valid), 64'h0);
        chk("rst_instr", 64'(id_instr), 64'h0);
        chk("rst_pc", id_pc, 64'h0);
        chk("rst_addr", imem_addr, RPC);
        mq.delete();
        m_disc    = 0;
        m_pc      = RPC;
        m_fetched = 0;
        m_dropped = 0;
`ifdef IF_PREFETCH_PERF_EN
        chk("rst_perf_f", 64'(perf_fetched), 64'h0);
        chk("rst_perf_d", 64'(perf_dropped), 64'h0);
`endif
        @(negedge clk);
        Reset = 1'b1;
    endtask

    task automatic set_knobs(input int g, input int rv, input int rdy, input int rd, input int sp);
        p_gnt   = g;
        p_rv    = rv;
        p_rdy   = rdy;
        p_redir = rd;
        p_spur  = sp;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic drain_mem();
        for (int k = 0; k < 50 && mem.size() > 0; k++) cycle();
        chk("mem_drained", 64'(mem.size()), 64'h0);
    endtask

    initial begin
        Reset       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        id_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        seq         = 0;
        f_redir     = 1'b0;
        f_rpc       = '0;
        set_knobs(0, 0, 0, 0, 0);

        do_reset();

        set_knobs(100, 100, 100, 0, 0);
        run(12);

        set_knobs(100, 100, 0, 0, 0);
        run(10);
        set_knobs(100, 100, 100, 0, 0);
        run(6);

        set_knobs(0, 100, 100, 0, 0);
        run(8);
        set_knobs(100, 0, 0, 0, 0);
        run(3);
        f_redir = 1'b1;
        f_rpc   = 64'h1003;
        cycle();
        set_knobs(100, 100, 100, 0, 0);
        run(10);

        set_knobs(0, 100, 100, 0, 0);
        run(5);
        set_knobs(100, 100, 100, 0, 0);
        run(4);

        set_knobs(0, 100, 100, 0, 0);
        drain_mem();
        run(2);
        set_knobs(0, 0, 100, 0, 100);
        run(4);

        set_knobs(60, 50, 60, 3, 10);
        run(2000);

        set_knobs(100, 40, 0, 0, 0);
        run(4);
        do_reset();
        set_knobs(0, 100, 100, 0, 0);
        drain_mem();
        set_knobs(100, 100, 100, 0, 0);
        run(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
Instruction fetch stage that sits directly upstream of the PROCESSOR decode stage. It generates sequential 64-bit PCs and issues word fetches over a req/gnt/rvalid handshake to instruction memory. It buffers returned instructions, tagged with their PCs, in a DEPTH-entry in-order queue. It presents them to decode with a valid/ready handshake and handles branch redirects by flushing the queue and discarding in-flight responses.

Parameters:
DEPTH, 4, queue slots and maximum outstanding fetches combined; power of two, minimum 2.
RESET_PC, 64'h0, fetch PC loaded at reset.

Ports:
clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset; Reset=0 resets the block.
imem_req  out  1  fetch request valid.
imem_addr  out  64  fetch address, always 4-byte aligned.
imem_gnt  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  response data valid; responses return in order, at most one per cycle, at least one cycle after the grant.
imem_rdata  in  32  instruction word.
id_valid  out  1  head instruction valid to decode.
id_instr  out  32  head instruction.
id_pc  out  64  PC of the head instruction.
id_ready  in  1  decode accepts the head entry; low while the pipeline is stalled.
redirect  in  1  branch or exception redirect pulse.
redirect_pc  in  64  new fetch PC; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC.
  - reserved count = 0; discard count = 0; all slots empty.
  - imem_req=0, id_valid=0, id_instr=0, id_pc=0, imem_addr=RESET_PC.
- Slot ring: head and tail pointers wrap modulo DEPTH. Each slot holds pc, instr and a filled flag.
- Issue:
  - imem_req = (reserved < DEPTH) && !redirect. It is computed from registered state only, so a same-cycle pop does not free a slot for that cycle.
  - imem_addr = fetch_pc.
  - On imem_req && imem_gnt: reserve the tail slot, store pc=fetch_pc with filled=0, advance tail, fetch_pc += 4 (wraps modulo 2^64), reserved++.
  - imem_req and imem_addr stay stable until granted.
- Response:
  - If discard > 0: drop the data and decrement discard.
  - Else if there is an unfilled reserved slot: write imem_rdata into the oldest unfilled slot and set its filled flag.
  - Else (spurious response): ignore it.
- Output:
  - id_valid = head slot filled; id_instr and id_pc come from the head slot.
  - No bypass: rvalid in cycle N gives id_valid in cycle N+1 at the earliest.
  - So the minimum grant-to-decode latency is 2 cycles.
- Pop: on id_valid && id_ready, clear the head slot, advance head, reserved--.
- Simultaneous events:
  - Grant and pop in the same cycle leave reserved unchanged.
  - Grant, rvalid and pop can all occur in one cycle.
- Redirect (highest priority):
  - In the redirect cycle: clear all slots, head=tail=0, reserved=0, fetch_pc = {redirect_pc[63:2],2'b00}.
  - discard += number of reserved-but-unfilled slots.
  - An rvalid in the same cycle counts toward the drop before the count is computed.
  - A pop in the same cycle is ignored; id_valid is 0 the next cycle.
  - imem_req=0 in the redirect cycle; fetching resumes the following cycle.
  - A back-to-back redirect accumulates discard correctly.
- Full: with reserved == DEPTH, no request is issued; the queue holds until decode pops.
- Empty: id_valid=0; id_instr and id_pc hold their last values.
- Reset mid-operation clears all state, including the discard count. Responses arriving after reset with nothing outstanding are ignored.

Optional Feature:
IF_PREFETCH_PERF_EN:
- Defined: adds output perf_fetched[31:0], which counts id_valid&&id_ready pops, and output perf_dropped[31:0], which counts discarded responses.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset=0 then released; memory grants every cycle with 1-cycle rvalid; id_ready=1 -> addresses 0,4,8,... in order; first id_valid 2 cycles after the first grant; id_pc 0,4,8 paired with the matching rdata.
- id_ready=0 with DEPTH=4 -> exactly 4 grants (pc 0..12), then imem_req=0; raising id_ready pops one entry per cycle, and imem_req reasserts the cycle after the first pop.
- Redirect to 64'h1003 with 3 responses outstanding -> next imem_addr=64'h1000; the 3 late responses are dropped; the first id_pc after redirect is 64'h1000.
- imem_gnt held low for 5 cycles -> imem_req=1 with imem_addr stable throughout; fetch_pc advances only on grant.
- Spurious imem_rvalid with nothing outstanding -> id_valid stays 0, no state change; with IF_PREFETCH_PERF_EN defined, perf_dropped still 0.
- Reset asserted mid-stream with 2 queued and 1 outstanding -> all outputs return to reset values immediately; the in-flight rvalid after release is ignored; fetch restarts at RESET_PC.
